// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan multiplexer: active-low glyphs,
// idle bus values and the digit index width.
package seg_pkg;

    localparam int IDX_W = 2;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] SEL_OFF = 4'hF;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b0000011;
    localparam logic [6:0] GLYPH_C = 7'b1000110;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational 4-bit value to active-low 7-segment glyph (0-9, then hex A-F).
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (value)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes a frame-coherent snapshot of four hex digits onto a
// common-anode 7-segment module with ghost blanking, zero suppression and blink.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 1000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        blank_lz,
    input  logic        blink_en,
    output logic [3:0]  select,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]    PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]    PRE_BLANK  = PW'(BLANK_CYC);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = '1;

    logic [PW-1:0]    prescaler;
    logic [IDX_W-1:0] idx;
    logic [15:0]      shadow;
    logic [BW-1:0]    blink_cnt;
    logic             blink_on;

    logic             step;
    logic             frame_start;
    logic [3:0]       cur_val;
    logic [15:0]      upper;
    logic             lz_hide;
    logic             visible;
    logic [6:0]       glyph;
    logic [3:0]       sel_nxt;
    logic [6:0]       seg_nxt;

    assign step        = (prescaler == PRE_LAST);
    assign frame_start = step && (idx == IDX_LAST);

    assign cur_val = shadow[{idx, 2'b00} +: 4];

    // Digit k hides when it and every more significant digit are zero
    assign upper   = shadow >> {idx, 2'b00};
    assign lz_hide = blank_lz && (idx != '0) && (upper == 16'h0000);
    assign visible = blink_on && !lz_hide;

    seg_glyph_rom u_glyph_rom (
        .value (cur_val),
        .glyph (glyph)
    );

    always_comb begin
        sel_nxt = SEL_OFF;
        seg_nxt = SEG_OFF;
        if ((prescaler >= PRE_BLANK) && visible) begin
            sel_nxt = ~(4'b0001 << idx);
            seg_nxt = glyph;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= '0;
            shadow     <= 16'h0000;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            select     <= SEL_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            prescaler <= step ? '0 : prescaler + 1'b1;
            if (step) begin
                idx <= idx + 1'b1;
            end
            if (frame_start) begin
                shadow <= digits;
            end
            // Blink only advances on frame boundaries so a lit frame is never cut short
            if (!blink_en) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (frame_start) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            select     <= sel_nxt;
            seg        <= seg_nxt;
            frame_tick <= frame_start;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux against a frame/slot arithmetic model.
module tb_seg_scan_mux;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;
    localparam int FR = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic        blank_lz = 1'b0;
    logic        blink_en = 1'b0;
    logic [3:0]  select;
    logic [6:0]  seg;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // model state: cycles since reset release, snapshot, blink bookkeeping
    int          n;
    logic [15:0] shadow_m;
    int          cnt_m;
    bit          phase_m;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [3:0] es;
    logic [6:0] eg;
    logic       ef;

    seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .select     (select),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        n        = 0;
        shadow_m = 16'h0000;
        cnt_m    = 0;
        phase_m  = 1'b1;
    endtask

    // Predicts the outputs registered at the coming edge, advances the model and the clock.
    task automatic tick(output logic [3:0] xs, output logic [6:0] xg, output logic xf);
        int p, s;
        bit fs, vis;
        logic [3:0] d;
        logic [3:0] one;
        p   = n % SD;
        s   = (n / SD) % 4;
        fs  = (p == SD - 1) && (s == 3);
        d   = 4'(shadow_m >> (4 * s));
        vis = phase_m && !(blank_lz && s != 0 && (shadow_m >> (4 * s)) == 16'h0);
        one = 4'b0001;
        xs  = 4'hF;
        xg  = 7'h7F;
        if (p >= BC && vis) begin
            xs = ~(one << s);
            xg = glyph_tab[d];
        end
        xf = fs;
        if (fs) shadow_m = digits;
        if (!blink_en) begin
            cnt_m   = 0;
            phase_m = 1'b1;
        end else if (fs) begin
            if (cnt_m == BF - 1) begin
                cnt_m   = 0;
                phase_m = !phase_m;
            end else begin
                cnt_m = cnt_m + 1;
            end
        end
        n = n + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic align(input int pos);
        for (int k = 0; k < 4 * FR && (n % FR) != pos; k++) tick(es, eg, ef);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({select, seg, frame_tick} !== {4'hF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_async got %b/%b/%b want 1111/1111111/0", select, seg, frame_tick);
        end
        digits = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({select, seg, frame_tick} !== {4'hF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_held got %b/%b/%b want 1111/1111111/0", select, seg, frame_tick);
        end
        rst = 1'b0;
        model_reset();
        repeat (3 * FR) begin
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL scan n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] pats [3] = '{16'h0070, 16'h0000, 16'h0070};
        logic        lzs  [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            digits   = pats[i];
            blank_lz = lzs[i];
            repeat (2 * FR) begin
                tick(es, eg, ef);
                checks++;
                if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                    errors++;
                    $display("FAIL lz%0d n=%0d got %b/%b/%b want %b/%b/%b", i, n, select, seg, frame_tick, es, eg, ef);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_snapshot();
        digits = 16'h1234;
        align(0);
        repeat (FR + SD + 4) tick(es, eg, ef);
        digits = 16'h5678;
        repeat (2 * FR) begin
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL snapshot n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
    endtask

    task automatic test_hex();
        digits = 16'h00AF;
        repeat (2 * FR) begin
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL hex n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
    endtask

    task automatic test_blink();
        int guard;
        digits = 16'h9876;
        align(0);
        blink_en = 1'b1;
        repeat (6 * FR) begin
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL blink n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
        guard = 0;
        while (!(phase_m == 1'b0 && (n % FR) == SD + 4) && guard < 8 * FR) begin
            tick(es, eg, ef);
            guard++;
        end
        checks++;
        if (guard >= 8 * FR) begin
            errors++;
            $display("FAIL blink_dark_frame not reached within %0d cycles", guard);
        end
        blink_en = 1'b0;
        repeat (FR + 8) begin
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL blink_drop n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            if ($urandom_range(0, 19) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 49) == 0) blank_lz = !blank_lz;
            if ($urandom_range(0, 59) == 0) blink_en = !blink_en;
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL random n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
        blink_en = 1'b0;
        blank_lz = 1'b0;
    endtask

    task automatic test_async_reset();
        digits = 16'h4321;
        repeat (FR) tick(es, eg, ef);
        align(SD + 4);
        checks++;
        if (select !== 4'b1101) begin
            errors++;
            $display("FAIL pre_reset_lit got sel=%b want 1101", select);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({select, seg, frame_tick} !== {4'hF, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL reset_midslot got %b/%b/%b want 1111/1111111/0", select, seg, frame_tick);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (FR + 4) begin
            tick(es, eg, ef);
            checks++;
            if ({select, seg, frame_tick} !== {es, eg, ef}) begin
                errors++;
                $display("FAIL post_reset n=%0d got %b/%b/%b want %b/%b/%b", n, select, seg, frame_tick, es, eg, ef);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_leading_zero();
        test_snapshot();
        test_hex();
        test_blink();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
Downstream display stage for the 4-digit score counter. Takes four 4-bit digit values and drives a common-anode 4-digit 7-segment module. It time-multiplexes the digits onto one segment bus using a refresh prescaler. Features: per-slot ghost-blanking interval, frame-coherent digit snapshot, optional leading-zero suppression, and end-of-game blink.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot; must be >= 2.
BLANK_CYC, 1000, cycles at the start of each slot with all digits off; must be < SCAN_DIV.
BLINK_FRAMES, 128, full frames per blink half-period.

Ports:
clk  in  1  system clock
rst  in  1  reset
digits  in  16  {d3,d2,d1,d0}; d0 = units, d3 = thousands
blank_lz  in  1  1 = suppress leading zeros
blink_en  in  1  1 = blink whole display (driven by game_end)
select  out  4  digit enables, active-low; select[k] drives digit k
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset: rst is asynchronous, active-high. All state clears immediately without a clock edge:
  - prescaler = 0, idx = 0, shadow = 16'h0000, blink counter = 0, blink phase = on.
  - select = 4'b1111, seg = 7'h7F, frame_tick = 0.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The wrap cycle is the step tick.
- On each step tick, idx advances 0→1→2→3→0.
- Frame start is the step tick where idx wraps 3→0. On that tick:
  - shadow <= digits.
  - frame_tick pulses for one cycle.
  - blink logic updates.
- Digits are always displayed from shadow. A change on digits mid-frame is not visible until the next frame, so the display never tears.
- Slot output, computed combinationally and then registered (outputs lag prescaler/idx by 1 cycle):
  - prescaler < BLANK_CYC: select = 1111, seg = 7F.
  - Otherwise, if the digit is visible: select = ~(1 << idx), seg = glyph(shadow digit idx).
  - Otherwise: select = 1111, seg = 7F.
- Visibility:
  - The digit is invisible if blink phase = off.
  - If blank_lz = 1, digit k (k ≥ 1) is invisible when shadow digits k..3 are all 0.
  - Digit 0 is never zero-suppressed, so value 0 shows a single "0".
- Glyphs, active-low:
  - Digits: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Values 10..15 show hex A,b,C,d,E,F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Blink:
  - When blink_en = 0: counter is held at 0 and phase is forced on, taking effect the next cycle.
  - When blink_en = 1: at each frame start the counter increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and phase toggles.
  - Asserting blink_en mid-frame does not change phase before the next frame start.
- Simultaneous events:
  - frame start with a digits change: the new value is captured.
  - frame start with a blink_en fall: phase = on.
- Reset mid-slot: outputs go dark at once. After release, scanning restarts at idx 0 with a full BLANK_CYC blank.

Decomposition:
- Package seg_pkg holds:
  - the glyph constants GLYPH_0..GLYPH_F,
  - SEG_OFF = 7'h7F,
  - SEL_OFF = 4'hF,
  - digit index width constant = 2.
- Sub-module seg_glyph_rom: pure combinational 4-bit value → 7-bit active-low glyph.
- Prescaler, slot sequencing, snapshot, blanking and blink stay in seg_scan_mux.

Test Plan:
(All with SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.)
1. Assert rst, then release with digits = 16'h1234 → outputs 1111/7F during reset. Per 8-cycle slot: 2 cycles dark, then 1110/0011001 ("4"), then slots 1101/0110000, 1011/0100100, 0111/1111001. frame_tick every 32 cycles.
2. digits = 16'h0070, blank_lz = 1 → slots 3 and 2 stay 1111. Slot 1 shows 1101/1111000, slot 0 shows 1110/1000000. digits = 0 → only slot 0 shows "0". With blank_lz = 0, all four digits are shown.
3. Change digits 1234→5678 during the slot-1 active window → slots 1..3 of that frame still show 3,2,1. The next frame shows 8,7,6,5.
4. digits = 16'h00AF → slot 0 shows 0001110 ("F"), slot 1 shows 0001000 ("A").
5. blink_en = 1 from a frame start → 2 frames lit, 2 frames with select = 1111 throughout, repeating. Drop blink_en during a dark frame → the next active window is lit.
6. Assert rst asynchronously between clock edges during the active window → select = 1111 and seg = 7F before the next posedge clk. After release, the first 2 cycles are dark and idx = 0.
